// File: rtl/serial_arith_pkg.sv
// Shared helpers for the bit-serial add/subtract family: bit order, counter
// sizing and the XOR/AND-only majority used for carry and borrow.
package serial_arith_pkg;

  // Words are streamed least-significant bit first.
  localparam bit LSB_FIRST = 1'b1;

  // Word-end flags, registered together in the top.
  typedef struct packed {
    logic done;
    logic lt;
    logic eq;
  } word_flags_t;

  // Counter width that stays legal (>=1) even for single-bit words.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // maj(x,y,z) written with XOR/AND only, so gate-level flows see no OR.
  function automatic logic maj_xor(input logic x, input logic y, input logic z);
    return z ^ ((x ^ z) & (y ^ z));
  endfunction

  function automatic logic carry_maj(input logic a, input logic b, input logic cin);
    return maj_xor(a, b, cin);
  endfunction

  // Borrow out of a - b - bin is the carry form with the minuend inverted.
  function automatic logic borrow_maj(input logic a, input logic b, input logic bin);
    return maj_xor(~a, b, bin);
  endfunction

endpackage

// File: rtl/sub_n_serial_if.sv
// Bit-serial subtractor stream bus: operand bits in, difference bit and
// word-end flags out.
interface sub_n_serial_if;
  logic [0:0] a;
  logic [0:0] b;
  logic       in_valid;
  logic [0:0] c;
  logic       c_valid;
  logic       done;
  logic       lt;
  logic       eq;

  modport master (
    output a, b, in_valid,
    input  c, c_valid, done, lt, eq
  );

  modport slave (
    input  a, b, in_valid,
    output c, c_valid, done, lt, eq
  );
endinterface

// File: rtl/sub_n_serial_fs_cell.sv
// One-bit full subtractor built from XOR/AND/INV gates only.
module fs_cell
  import serial_arith_pkg::*;
(
  input  logic i_a,
  input  logic i_b,
  input  logic i_bin,
  output logic o_d,
  output logic o_bout
);

  assign o_d    = i_a ^ i_b ^ i_bin;
  assign o_bout = borrow_maj(i_a, i_b, i_bin);

endmodule

// File: rtl/sub_n_serial.sv
// Bit-serial unsigned subtractor c = a - b over N-bit LSB-first words, with
// borrow-out (a<b) and equality flags registered at each word end.
module sub_n_serial
  import serial_arith_pkg::*;
#(
  parameter int N = 1024
) (
  input  logic         clk,
  input  logic         rst,
  sub_n_serial_if.slave bus
);

  localparam int CNT_W = clog2_min1(N);
  localparam logic [CNT_W-1:0] IDX_FIRST = LSB_FIRST ? '0 : CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] IDX_LAST  = LSB_FIRST ? CNT_W'(N - 1) : '0;

  logic             r_borrow;
  logic [CNT_W-1:0] r_idx;
  logic             r_neq;
  word_flags_t      r_flags;

  logic w_diff;
  logic w_borrow_n;
  logic w_ab_xor;
  logic w_last;

  fs_cell u_fs_cell (
    .i_a    (bus.a[0]),
    .i_b    (bus.b[0]),
    .i_bin  (r_borrow),
    .o_d    (w_diff),
    .o_bout (w_borrow_n)
  );

  assign w_ab_xor = bus.a[0] ^ bus.b[0];
  assign w_last   = (r_idx == IDX_LAST);

  // Borrow, counter and inequality tracker are cleared at every word end so
  // nothing from one frame leaks into the next.
  // NOTE: async reset in the sensitivity list; every register here uses <=
  // so all of them update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_borrow <= 1'b0;
      r_idx    <= IDX_FIRST;
      r_neq    <= 1'b0;
      r_flags  <= '0;
    end else begin
      r_flags.done <= 1'b0;
      if (bus.in_valid) begin
        if (w_last) begin
          r_flags.done <= 1'b1;
          r_flags.lt   <= w_borrow_n;
          r_flags.eq   <= ~(r_neq | w_ab_xor);
          r_borrow     <= 1'b0;
          r_idx        <= IDX_FIRST;
          r_neq        <= 1'b0;
        end else begin
          r_borrow <= w_borrow_n;
          r_idx    <= LSB_FIRST ? r_idx + CNT_W'(1) : r_idx - CNT_W'(1);
          r_neq    <= r_neq | w_ab_xor;
        end
      end
    end
  end

  // Difference is driven every cycle; consumers qualify it with c_valid.
  assign bus.c[0]    = w_diff;
  assign bus.c_valid = bus.in_valid;
  assign bus.done    = r_flags.done;
  assign bus.lt      = r_flags.lt;
  assign bus.eq      = r_flags.eq;

endmodule

// File: tb/tb_sub_n_serial.sv
// Directed and randomized checks of sub_n_serial at N=8, N=1 and N=1024
// against a wide-arithmetic golden model.
module tb_sub_n_serial;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sub_n_serial_if if8 ();
  sub_n_serial_if if1 ();
  sub_n_serial_if ifk ();

  sub_n_serial #(.N(8))    u_dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  sub_n_serial #(.N(1))    u_dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sub_n_serial #(.N(1024)) u_dutk (.clk(clk), .rst(rst), .bus(ifk.slave));

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] flags(input int sel);
    case (sel)
      8:       return {if8.done, if8.lt, if8.eq};
      1:       return {if1.done, if1.lt, if1.eq};
      default: return {ifk.done, ifk.lt, ifk.eq};
    endcase
  endfunction

  // Drive one beat, sample c mid-cycle, return just after the next rising edge.
  task automatic beat(input int sel, input logic a, input logic b, input logic v,
                      output logic c);
    if8.a = a; if1.a = a; ifk.a = a;
    if8.b = b; if1.b = b; ifk.b = b;
    if8.in_valid = v && (sel == 8);
    if1.in_valid = v && (sel == 1);
    ifk.in_valid = v && (sel == 1024);
    #1;
    case (sel)
      8:       c = if8.c[0];
      1:       c = if1.c[0];
      default: c = ifk.c[0];
    endcase
    @(posedge clk);
    #1;
  endtask

  // Stream one word; optionally stall after bit stall_after. Counts any done
  // seen before the final valid beat.
  task automatic word(input int sel, input int n, input logic [1023:0] a,
                      input logic [1023:0] b, input int stall_after, input int stall_len,
                      output logic [1023:0] c, output int early_done);
    logic cb;
    logic [2:0] f;
    early_done = 0;
    c = '0;
    for (int i = 0; i < n; i++) begin
      beat(sel, a[i], b[i], 1'b1, cb);
      c[i] = cb;
      f = flags(sel);
      if (i != n - 1 && f[2]) early_done++;
      if (i == stall_after) begin
        for (int s = 0; s < stall_len; s++) begin
          beat(sel, 1'b1, 1'b0, 1'b0, cb);
          f = flags(sel);
          if (f[2]) early_done++;
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1023:0] wa, wb, wc, wexp;
    int            early;
    logic [2:0]    f;
    logic          cb;
    int            bad;
    logic [7:0]    a8, b8;

    rst = 1'b1;
    if8.a = 1'b1; if1.a = 1'b1; ifk.a = 1'b1;
    if8.b = 1'b0; if1.b = 1'b0; ifk.b = 1'b0;
    if8.in_valid = 1'b0; if1.in_valid = 1'b0; ifk.in_valid = 1'b0;
    #12;
    check("rst_flags8", {61'd0, flags(8)}, 64'd0);
    check("rst_flags1", {61'd0, flags(1)}, 64'd0);
    check("rst_c_comb", {63'd0, if8.c[0]}, 64'd1);
    check("rst_c_valid", {63'd0, if8.c_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // 0x05 - 0x03
    word(8, 8, 1024'h05, 1024'h03, -1, 0, wc, early);
    check("w1_c", wc[63:0], 64'h02);
    check("w1_early_done", early, 0);
    f = flags(8);
    check("w1_flags", {61'd0, f}, 64'b100);
    beat(8, 1'b0, 1'b0, 1'b0, cb);
    f = flags(8);
    check("w1_done_drop", {61'd0, f}, 64'b000);

    // 0x03 - 0x05 then 0x00 - 0x00 back-to-back
    word(8, 8, 1024'h03, 1024'h05, -1, 0, wc, early);
    check("w2_c", wc[63:0], 64'hFE);
    f = flags(8);
    check("w2_flags", {61'd0, f}, 64'b110);
    word(8, 8, 1024'h00, 1024'h00, -1, 0, wc, early);
    check("w3_c", wc[63:0], 64'h00);
    check("w3_early_done", early, 0);
    f = flags(8);
    check("w3_flags", {61'd0, f}, 64'b101);

    // 0xA5 - 0xA5 with a 3-cycle stall after bit 3
    word(8, 8, 1024'hA5, 1024'hA5, 3, 3, wc, early);
    check("w4_c", wc[63:0], 64'h00);
    check("w4_early_done", early, 0);
    f = flags(8);
    check("w4_flags", {61'd0, f}, 64'b101);

    // 0xFF - 0x01 aborted by reset after bit 4, then 0x10 - 0x01
    for (int i = 0; i < 5; i++) beat(8, 1'b1, (i == 0), 1'b1, cb);
    if8.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_flags", {61'd0, flags(8)}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_no_done", {61'd0, flags(8)}, 64'd0);
    word(8, 8, 1024'h10, 1024'h01, -1, 0, wc, early);
    check("w5_c", wc[63:0], 64'h0F);
    check("w5_early_done", early, 0);
    f = flags(8);
    check("w5_flags", {61'd0, f}, 64'b100);

    // N=1: every beat is a word end
    word(1, 1, 1024'h0, 1024'h1, -1, 0, wc, early);
    check("n1_0_c", wc[0], 1);
    check("n1_0_flags", {61'd0, flags(1)}, 64'b110);
    word(1, 1, 1024'h1, 1024'h1, -1, 0, wc, early);
    check("n1_1_c", wc[0], 0);
    check("n1_1_flags", {61'd0, flags(1)}, 64'b101);
    word(1, 1, 1024'h1, 1024'h0, -1, 0, wc, early);
    check("n1_2_c", wc[0], 1);
    check("n1_2_flags", {61'd0, flags(1)}, 64'b100);

    // Random N=8 words against (a-b) mod 256
    for (int w = 0; w < 1000; w++) begin
      a8 = 8'($urandom);
      b8 = (w % 4 == 0) ? a8 : 8'($urandom);
      wa = '0; wb = '0;
      wa[7:0] = a8;
      wb[7:0] = b8;
      word(8, 8, wa, wb, -1, 0, wc, early);
      wexp = '0;
      wexp[7:0] = a8 - b8;
      f = flags(8);
      check("r8_c", wc[63:0], wexp[63:0]);
      check("r8_lt", f[1], a8 < b8);
      check("r8_eq", f[0], a8 == b8);
      check("r8_done", {f[2], 31'd0} | early, 32'h8000_0000);
    end

    // Random N=1024 words against (a-b) mod 2^1024
    for (int w = 0; w < 30; w++) begin
      for (int j = 0; j < 32; j++) begin
        wa[j*32 +: 32] = $urandom;
        wb[j*32 +: 32] = $urandom;
      end
      if (w % 3 == 0) wb = wa;
      if (w % 5 == 1) wb[1023:1000] = wa[1023:1000];
      word(1024, 1024, wa, wb, -1, 0, wc, early);
      wexp = wa - wb;
      bad = 0;
      for (int i = 0; i < 1024; i++) if (wc[i] !== wexp[i]) bad++;
      f = flags(1024);
      check("rk_c_bad_bits", bad, 0);
      check("rk_lt", f[1], wa < wb);
      check("rk_eq", f[0], wa == wb);
      check("rk_done", {f[2], 31'd0} | early, 32'h8000_0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
